apb_uart_tx: RTL

APB slave that accepts bytes from the APB_Protocol master bridge and serialises them onto a UART TX line in 8N1 format. It sits directly downstream of the bridge, on the UART select of the APB bus. It provides three registers: TX data push, status and baud divisor. Bytes are buffered in a small FIFO so the master can post several writes back-to-back.

---
 rtl/apb_uart_tx_if.sv | 28 ++
 rtl/apb_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_uart_tx_if
//  Purpose  : APB3 completer-side signal bundle between the bridge and the
//             UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_uart_tx_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : apb_uart_tx
//  Purpose  : APB slave with a small TX FIFO feeding an 8N1 UART serialiser.
//  Revision : 1.0  initial release
// ============================================================================
module apb_uart_tx #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  wire logic     PCLK,
    input  wire logic     PRESETn,
    apb_uart_tx_if.slave  apb,
    output logic          uart_tx
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [1:0]      c_REG_TXDATA = 2'd0;
    localparam logic [1:0]      c_REG_STATUS = 2'd1;
    localparam logic [1:0]      c_REG_BAUD   = 2'd2;
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL   = c_CW'(FIFO_DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE    = c_AW'(1);
    localparam logic [15:0]     c_BAUD_ONE   = 16'd1;
    localparam logic [2:0]      c_BIT_LAST   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_tx;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [15:0]     r_baud_cnt;
    logic [15:0]     r_baud_div;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            w_access;
    logic            w_addr_ok;
    logic [1:0]      w_reg;
    logic            w_sel_tx;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_push;
    logic            w_pop;
    logic            w_baud_wr;
    logic            w_bit_end;
    logic [31:0]     w_status;
    logic [31:0]     w_prdata;
    logic            w_unused_bits;

    // ------------------------------------------------------------------
    // APB decode: only the access phase has side effects
    // ------------------------------------------------------------------
    assign w_access  = apb.PSEL & apb.PENABLE;
    assign w_reg     = apb.PADDR[3:2];
    assign w_addr_ok = (apb.PADDR[7:4] == 4'h0) && (w_reg != 2'd3);
    assign w_sel_tx  = w_access & w_addr_ok & (w_reg == c_REG_TXDATA);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != S_IDLE);
    // Full is judged on the pre-edge count, so a same-edge pop never rescues a write
    assign w_push    = w_sel_tx & apb.PWRITE & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_baud_wr = w_access & w_addr_ok & apb.PWRITE & (w_reg == c_REG_BAUD);

    assign w_status  = {25'd0, 3'(r_count), 1'b0, w_busy, w_empty, w_full};

    always_comb begin
        w_prdata = 32'd0;
        if (w_access && !apb.PWRITE && w_addr_ok) begin
            case (w_reg)
                c_REG_STATUS: w_prdata = w_status;
                c_REG_BAUD:   w_prdata = {16'd0, r_baud_div};
                default:      w_prdata = 32'd0;
            endcase
        end
    end

    assign apb.PRDATA  = w_prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_access & (~w_addr_ok | (w_sel_tx & apb.PWRITE & w_full));

    assign w_unused_bits = ^{apb.PWDATA[31:16], apb.PADDR[1:0]};

    // ------------------------------------------------------------------
    // Baud divisor register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_baud_div <= DEFAULT_DIV;
        end else if (w_baud_wr) begin
            r_baud_div <= apb.PWDATA[15:0];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO: circular buffer, pointers wrap naturally at power-of-two depth
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= apb.PWDATA[7:0];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser. A '>=' boundary lets a divisor shrunk mid-bit end the
    // current bit promptly instead of wrapping through 65536 counts.
    // ------------------------------------------------------------------
    assign w_bit_end = (r_baud_cnt >= r_baud_div);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_baud_cnt <= 16'd0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        r_bit_cnt  <= 3'd0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign uart_tx = r_tx;

endmodule
`default_nettype wire
